// File: rtl/move_judger_pkg.sv
// move_judger_pkg: result, cell, side and direction codes shared by the move judger
package move_judger_pkg;
  localparam logic [1:0] JUDGER_NONE    = 2'b00;
  localparam logic [1:0] JUDGER_VALID   = 2'b01;
  localparam logic [1:0] JUDGER_WIN     = 2'b10;
  localparam logic [1:0] JUDGER_INVALID = 2'b11;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_RED   = 2'b01;
  localparam logic [1:0] CELL_GREEN = 2'b10;
  localparam logic SIDE_RED   = 1'b0;
  localparam logic SIDE_GREEN = 1'b1;
  localparam logic SCAN_POS = 1'b0;
  localparam logic SCAN_NEG = 1'b1;
  localparam logic [1:0] DIR_H    = 2'd0;
  localparam logic [1:0] DIR_V    = 2'd1;
  localparam logic [1:0] DIR_DIAG = 2'd2;
  localparam logic [1:0] DIR_ANTI = 2'd3;
  typedef enum logic [2:0] {IDLE, C_ISSUE, C_SAMPLE, STEP, S_ISSUE, S_SAMPLE, EVAL, DONE} state_t;
  function automatic logic [1:0] cell_of(input logic color);
    return (color == SIDE_GREEN) ? CELL_GREEN : CELL_RED;
  endfunction
endpackage

// File: rtl/move_judger_dir_step.sv
// judger_dir_step: one step of the cursor along a scan direction, flagging steps that leave the board
module judger_dir_step
  import move_judger_pkg::*;
#(
  parameter int EDGE_ADDR_BITS = 3
) (
  input  logic [EDGE_ADDR_BITS-1:0] cx,
  input  logic [EDGE_ADDR_BITS-1:0] cy,
  input  logic [1:0]                dir,
  input  logic                      side,
  output logic [EDGE_ADDR_BITS-1:0] nx,
  output logic [EDGE_ADDR_BITS-1:0] ny,
  output logic                      off_board
);
  localparam int W = EDGE_ADDR_BITS + 1;
  localparam logic [W-1:0] ONE = W'(1);
  logic [W-1:0] dx, dy, sx, sy;
  // pick the per-direction delta; the negative side walks the opposite way
  always_comb begin
    dx = '0;
    dy = '0;
    case (dir)
      DIR_H:    dx = ONE;
      DIR_V:    dy = ONE;
      DIR_DIAG: begin dx = ONE; dy = ONE; end
      default:  begin dx = ONE; dy = -ONE; end
    endcase
    if (side == SCAN_NEG) begin
      dx = -dx;
      dy = -dy;
    end
  end
  assign sx = {1'b0, cx} + dx;
  assign sy = {1'b0, cy} + dy;
  assign nx = sx[W-2:0];
  assign ny = sy[W-2:0];
  assign off_board = sx[W-1] | sy[W-1];
endmodule

// File: rtl/move_judger.sv
// move_judger: judges a gomoku move as invalid, valid or winning by scanning RAM; MOVE_JUDGER_EXACT_LEN_EN makes only exact-length runs win
module move_judger
  import move_judger_pkg::*;
#(
  parameter int EDGE_ADDR_BITS = 3,
  parameter int DATA_BITS      = 2,
  parameter int WIN_LEN        = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        color,
  input  logic [2*EDGE_ADDR_BITS-1:0] pos,
  output logic [2*EDGE_ADDR_BITS-1:0] ram_rd_addr,
  input  logic [DATA_BITS-1:0]        ram_data,
  output logic [1:0]                  result,
  output logic                        done
);
  localparam int EW = EDGE_ADDR_BITS;
  localparam int AW = 2 * EDGE_ADDR_BITS;
  localparam int RUN_MAX = 2 * (WIN_LEN - 1) + 1;
  localparam int RW = $clog2(RUN_MAX + 1);
`ifdef MOVE_JUDGER_EXACT_LEN_EN
  localparam int SIDE_LIM = WIN_LEN;
`else
  localparam int SIDE_LIM = WIN_LEN - 1;
`endif
  localparam int CW = $clog2(SIDE_LIM + 1);
  state_t state, state_d;
  logic [AW-1:0] pos_q, pos_d, cur, cur_d, addr_d;
  logic color_q, color_d, side, side_d, off, end_side, win;
  logic [1:0] dir, dir_d, result_d;
  logic [RW-1:0] run, run_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [EW-1:0] nx, ny;
  judger_dir_step #(.EDGE_ADDR_BITS(EW)) u_step (
    .cx(cur[EW-1:0]), .cy(cur[AW-1:EW]), .dir(dir), .side(side),
    .nx(nx), .ny(ny), .off_board(off)
  );
`ifdef MOVE_JUDGER_EXACT_LEN_EN
  assign win = run == RW'(WIN_LEN);
`else
  assign win = run >= RW'(WIN_LEN);
`endif
  assign done = (state == DONE) && en;
  // next-state and datapath updates; dropping en anywhere outside IDLE aborts without a result
  always_comb begin
    state_d = state;
    pos_d = pos_q;
    color_d = color_q;
    cur_d = cur;
    addr_d = ram_rd_addr;
    dir_d = dir;
    side_d = side;
    run_d = run;
    cnt_d = cnt;
    result_d = result;
    end_side = 1'b0;
    if (state != IDLE && !en) begin
      state_d = IDLE;
      result_d = JUDGER_NONE;
    end else begin
      case (state)
        IDLE: if (en) begin
          pos_d = pos;
          color_d = color;
          addr_d = pos;
          state_d = C_ISSUE;
        end
        C_ISSUE: state_d = C_SAMPLE;
        C_SAMPLE: if (ram_data != CELL_EMPTY) begin
          result_d = JUDGER_INVALID;
          state_d = DONE;
        end else begin
          dir_d = DIR_H;
          run_d = RW'(1);
          side_d = SCAN_POS;
          cur_d = pos_q;
          cnt_d = '0;
          state_d = STEP;
        end
        STEP: if (off || cnt == CW'(SIDE_LIM)) begin
          end_side = 1'b1;
        end else begin
          addr_d = {ny, nx};
          state_d = S_ISSUE;
        end
        S_ISSUE: state_d = S_SAMPLE;
        S_SAMPLE: if (ram_data == cell_of(color_q)) begin
          run_d = run + RW'(run != RW'(RUN_MAX));
          cnt_d = cnt + CW'(1);
          cur_d = ram_rd_addr;
          state_d = STEP;
        end else begin
          end_side = 1'b1;
        end
        EVAL: if (win) begin
          result_d = JUDGER_WIN;
          state_d = DONE;
        end else if (dir == DIR_ANTI) begin
          result_d = JUDGER_VALID;
          state_d = DONE;
        end else begin
          dir_d = dir + 2'd1;
          run_d = RW'(1);
          side_d = SCAN_POS;
          cur_d = pos_q;
          cnt_d = '0;
          state_d = STEP;
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
      if (end_side) begin
        cur_d = pos_q;
        cnt_d = '0;
        side_d = SCAN_NEG;
        state_d = (side == SCAN_POS) ? STEP : EVAL;
      end
    end
  end
  // state, scan counters, RAM address and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pos_q <= '0;
      color_q <= 1'b0;
      cur <= '0;
      ram_rd_addr <= '0;
      dir <= '0;
      side <= SCAN_POS;
      run <= '0;
      cnt <= '0;
      result <= JUDGER_NONE;
    end else begin
      state <= state_d;
      pos_q <= pos_d;
      color_q <= color_d;
      cur <= cur_d;
      ram_rd_addr <= addr_d;
      dir <= dir_d;
      side <= side_d;
      run <= run_d;
      cnt <= cnt_d;
      result <= result_d;
    end
  end
endmodule
